// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU control path: sequencer states,
// control opcodes and default-width address/instruction types.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        HALT    = 3'd4
    } seq_state_t;

    localparam logic [3:0] HALT_OPCODE = 4'hF;
    localparam logic [3:0] JUMP_OPCODE = 4'hE;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] instr_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with increment enable that sticks at its all-ones maximum.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-decode-execute sequencer: owns the PC, handshakes instruction fetches,
// decodes HALT/JUMP locally and hands all other instructions to the execute unit.
module fetch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned                 ADDR_WIDTH   = 32,
    parameter int unsigned                 DATA_WIDTH   = 32,
    parameter int unsigned                 OPCODE_WIDTH = 4,
    parameter logic [OPCODE_WIDTH-1:0]     HALT_OPCODE  = OPCODE_WIDTH'(cpu_ctrl_pkg::HALT_OPCODE),
    parameter logic [OPCODE_WIDTH-1:0]     JUMP_OPCODE  = OPCODE_WIDTH'(cpu_ctrl_pkg::JUMP_OPCODE),
    parameter logic [ADDR_WIDTH-1:0]       PC_STEP      = ADDR_WIDTH'(1),
    parameter logic [ADDR_WIDTH-1:0]       RESET_VECTOR = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  ir_load,
    output logic                  exec_start,
    input  logic                  exec_done,
    input  logic                  resume,
    output logic [ADDR_WIDTH-1:0] pc_value,
    output logic                  halted,
    output logic [31:0]           retired_count,
    output logic [2:0]            state_dbg
);

    seq_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic                    mem_req_q, ir_load_q, exec_start_q, halted_q;
    logic                    retire;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_in;
    logic [ADDR_WIDTH-1:0]   jump_target;

    assign opcode_q    = instr_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign opcode_in   = mem_rdata[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign jump_target = {{OPCODE_WIDTH{1'b0}}, instr_q[ADDR_WIDTH-OPCODE_WIDTH-1:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        retire  = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (opcode_q == HALT_OPCODE) begin
                    state_d = HALT;
                end else if (opcode_q == JUMP_OPCODE) begin
                    pc_d    = jump_target;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                if (exec_done) begin
                    pc_d    = pc_q + PC_STEP;
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            HALT: begin
                if (resume) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulses are registered at the fetch-accept edge, so ir_load and exec_start
    // are both visible during the single DECODE cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VECTOR;
            instr_q      <= '0;
            mem_req_q    <= 1'b0;
            ir_load_q    <= 1'b0;
            exec_start_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            mem_req_q    <= (state_d == FETCH);
            halted_q     <= (state_d == HALT);
            ir_load_q    <= (state_q == FETCH) && mem_ready;
            exec_start_q <= (state_q == FETCH) && mem_ready &&
                            (opcode_in != HALT_OPCODE) && (opcode_in != JUMP_OPCODE);
        end
    end

    sat_counter #(
        .WIDTH(32)
    ) u_retired (
        .clk_i  (clock),
        .rst_ni (reset),
        .inc_i  (retire),
        .count_o(retired_count)
    );

    assign mem_req    = mem_req_q;
    assign mem_addr   = pc_q;
    assign pc_value   = pc_q;
    assign ir_load    = ir_load_q;
    assign exec_start = exec_start_q;
    assign halted     = halted_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: bench-side memory/execute responders
// and an architectural program model that predicts fetch order and counters.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, ir_load, exec_start, halted;
    logic        mem_ready = 1'b0;
    logic        exec_done = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] mem_addr, pc_value, retired_count;
    logic [31:0] mem_rdata = 32'h0;
    logic [2:0]  state_dbg;

    logic        reset_s = 1'b0;
    logic        mem_req_s, ir_load_s, exec_start_s, halted_s;
    logic        mem_ready_s = 1'b1;
    logic        exec_done_s = 1'b1;
    logic        resume_s = 1'b0;
    logic [4:0]  mem_addr_s, pc_value_s;
    logic [31:0] mem_rdata_s = 32'h0;
    logic [31:0] retired_s;
    logic [2:0]  state_s;

    logic        sc_rst_n = 1'b0;
    logic        sc_inc = 1'b0;
    logic [2:0]  sc_count;

    int checks = 0;
    int errors = 0;

    int mem_lat = 1;
    int exec_lat = 2;
    bit noise = 1'b0;
    logic [31:0] prog [logic [31:0]];
    logic [31:0] fetch_q [$];
    logic [31:0] exp_q [$];
    int ir_cnt = 0;
    int es_cnt = 0;
    int addr_viol = 0;
    int wait_cnt = 0;
    int ex_cnt = 0;
    bit ex_busy = 1'b0;

    always #5 clock = ~clock;

    fetch_sequencer dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ir_load(ir_load), .exec_start(exec_start), .exec_done(exec_done), .resume(resume),
        .pc_value(pc_value), .halted(halted), .retired_count(retired_count), .state_dbg(state_dbg)
    );

    fetch_sequencer #(.ADDR_WIDTH(5)) dut_small (
        .clock(clock), .reset(reset_s),
        .mem_req(mem_req_s), .mem_addr(mem_addr_s), .mem_ready(mem_ready_s), .mem_rdata(mem_rdata_s),
        .ir_load(ir_load_s), .exec_start(exec_start_s), .exec_done(exec_done_s), .resume(resume_s),
        .pc_value(pc_value_s), .halted(halted_s), .retired_count(retired_s), .state_dbg(state_s)
    );

    sat_counter #(.WIDTH(3)) u_sat (
        .clk_i(clock), .rst_ni(sc_rst_n), .inc_i(sc_inc), .count_o(sc_count)
    );

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return prog.exists(a) ? prog[a] : 32'h0;
    endfunction

    // Memory and execute-unit responders plus pulse monitors, all at negedge.
    always @(negedge clock) begin
        if (!reset) begin
            mem_ready = 1'b0;
            exec_done = 1'b0;
            ex_busy   = 1'b0;
            wait_cnt  = 0;
        end else begin
            if (ir_load) ir_cnt++;
            if (exec_start) es_cnt++;
            if (mem_req && (mem_addr !== pc_value)) addr_viol++;
            if (mem_req) begin
                if (wait_cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_read(mem_addr);
                    fetch_q.push_back(mem_addr);
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = noise ? $urandom : 32'h0;
                    wait_cnt++;
                end
            end else begin
                wait_cnt  = 0;
                mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = noise ? $urandom : 32'h0;
            end
            if (exec_start) begin
                ex_busy   = 1'b1;
                ex_cnt    = 0;
                exec_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (ex_busy) begin
                ex_cnt++;
                exec_done = 1'b0;
                if (ex_cnt >= exec_lat) begin
                    exec_done = 1'b1;
                    ex_busy   = 1'b0;
                end
            end else begin
                exec_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        resume = 1'b0;
        tick();
        tick();
        fetch_q.delete();
        ir_cnt    = 0;
        es_cnt    = 0;
        addr_viol = 0;
        reset     = 1'b1;
    endtask

    // Architectural model from PC 0: fills exp_q with the first n fetch addresses;
    // counts retirements and executes of the n-1 instructions before the last fetch.
    task automatic model_run(input int n, output int retired, output int execs);
        logic [31:0] pc;
        logic [31:0] ins;
        pc = 32'h0;
        retired = 0;
        execs = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pc);
            if (i == n - 1) break;
            ins = mem_read(pc);
            if (ins[31:28] == 4'hF) begin
                pc = pc + 32'd1;
            end else if (ins[31:28] == 4'hE) begin
                retired++;
                pc = {4'h0, ins[27:0]};
            end else begin
                retired++;
                execs++;
                pc = pc + 32'd1;
            end
        end
    endtask

    task automatic run_fetches(input int n, input bit auto_res, output bit to);
        int cyc;
        cyc = 0;
        to = 1'b0;
        while (fetch_q.size() < n) begin
            if (cyc >= 8000) begin
                to = 1'b1;
                break;
            end
            if (auto_res && halted && ($urandom_range(0, 2) == 0)) resume = 1'b1;
            else resume = (noise && !halted) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            cyc++;
        end
        resume = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({state_dbg, pc_value, retired_count} !== {3'd0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: state=%0d pc=%h ret=%0d want 0/0/0", state_dbg, pc_value, retired_count);
        end
        checks++;
        if ({mem_req, ir_load, exec_start, halted} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: req/ir/es/halt=%b want 0000", {mem_req, ir_load, exec_start, halted});
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({state_dbg, mem_req} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL release_idle: state=%0d req=%b want 0/0", state_dbg, mem_req);
        end
        tick();
        checks++;
        if ({state_dbg, mem_req, mem_addr} !== {3'd1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL first_fetch: state=%0d req=%b addr=%h want 1/1/0", state_dbg, mem_req, mem_addr);
        end
    endtask

    task automatic test_program(input string name, input int n, input bit auto_res);
        bit to;
        int exp_ret, exp_es;
        do_reset();
        model_run(n, exp_ret, exp_es);
        run_fetches(n, auto_res, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_timeout: fetches=%0d want %0d", name, fetch_q.size(), n);
        end
        for (int i = 0; i < fetch_q.size() && i < n; i++) begin
            checks++;
            if (fetch_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_addr[%0d]: got %h want %h", name, i, fetch_q[i], exp_q[i]);
            end
        end
        checks++;
        if (retired_count !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL %s_retired: got %0d want %0d", name, retired_count, exp_ret);
        end
        checks++;
        if ({ir_cnt, es_cnt, addr_viol} !== {n - 1, exp_es, 0}) begin
            errors++;
            $display("FAIL %s_pulses: ir=%0d es=%0d addrviol=%0d want %0d/%0d/0", name, ir_cnt, es_cnt, addr_viol, n - 1, exp_es);
        end
    endtask

    task automatic test_sequential();
        prog.delete();
        noise = 1'b0; mem_lat = 1; exec_lat = 2;
        test_program("seq", 4, 1'b0);
    endtask

    task automatic test_fetch_stall();
        int seen;
        prog.delete();
        noise = 1'b0; mem_lat = 5; exec_lat = 2;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({mem_req, mem_addr, ir_load} !== {1'b1, 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: req=%b addr=%h ir=%b want 1/0/0", i, mem_req, mem_addr, ir_load);
            end
        end
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            tick();
            if (ir_load) seen = 1;
        end
        tick(); tick(); tick();
        checks++;
        if ({seen, ir_cnt} !== {1, 1}) begin
            errors++;
            $display("FAIL stall_irload: seen=%0d count=%0d want 1/1", seen, ir_cnt);
        end
    endtask

    task automatic test_jump();
        prog.delete();
        prog[32'h2] = 32'hE000_0040;
        noise = 1'b0; mem_lat = $urandom_range(0, 2); exec_lat = $urandom_range(1, 3);
        test_program("jump", 5, 1'b0);
    endtask

    task automatic test_halt();
        int cyc;
        prog.delete();
        prog[32'h5] = 32'hF000_0000;
        noise = 1'b0; mem_lat = 1; exec_lat = 2;
        do_reset();
        cyc = 0;
        while (!halted && cyc < 2000) begin
            tick();
            cyc++;
        end
        checks++;
        if ({halted, mem_req, state_dbg, pc_value, retired_count} !== {1'b1, 1'b0, 3'd4, 32'h5, 32'd5}) begin
            errors++;
            $display("FAIL halt_enter: halt=%b req=%b state=%0d pc=%h ret=%0d want 1/0/4/5/5",
                     halted, mem_req, state_dbg, pc_value, retired_count);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({halted, mem_req} !== 2'b10) begin
                errors++;
                $display("FAIL halt_hold[%0d]: halt/req=%b want 10", i, {halted, mem_req});
            end
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        checks++;
        if ({halted, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h6}) begin
            errors++;
            $display("FAIL halt_resume: halt=%b req=%b addr=%h want 0/1/6", halted, mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_mid_execute();
        int cyc;
        bit to;
        prog.delete();
        noise = 1'b0; mem_lat = 1; exec_lat = 20;
        do_reset();
        cyc = 0;
        while (!(state_dbg == 3'd3 && pc_value == 32'h7) && cyc < 2000) begin
            tick();
            cyc++;
        end
        tick(); tick();
        checks++;
        if ({state_dbg, pc_value} !== {3'd3, 32'h7}) begin
            errors++;
            $display("FAIL rst_exec_reach: state=%0d pc=%h want 3/7", state_dbg, pc_value);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({state_dbg, pc_value, retired_count, mem_req, ir_load, exec_start, halted} !== {3'd0, 32'h0, 32'h0, 4'b0}) begin
            errors++;
            $display("FAIL rst_exec_async: state=%0d pc=%h ret=%0d pulses=%b want all 0",
                     state_dbg, pc_value, retired_count, {mem_req, ir_load, exec_start, halted});
        end
        tick();
        fetch_q.delete();
        ir_cnt = 0;
        es_cnt = 0;
        reset = 1'b1;
        exec_lat = 2;
        run_fetches(1, 1'b0, to);
        checks++;
        if ({to, ir_cnt, es_cnt} !== {1'b0, 0, 0}) begin
            errors++;
            $display("FAIL rst_exec_release: timeout=%b ir=%0d es=%0d want 0/0/0", to, ir_cnt, es_cnt);
        end
        checks++;
        if (fetch_q.size() < 1 || fetch_q[0] !== 32'h0) begin
            errors++;
            $display("FAIL rst_exec_refetch: got %h want 00000000", fetch_q.size() > 0 ? fetch_q[0] : 32'hx);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        reset_s = 1'b0;
        tick();
        reset_s = 1'b1;
        cyc = 0;
        while (!(mem_req_s && mem_addr_s == 5'h1F) && cyc < 500) begin
            tick();
            cyc++;
        end
        checks++;
        if ({mem_req_s, mem_addr_s, retired_s} !== {1'b1, 5'h1F, 32'd31}) begin
            errors++;
            $display("FAIL wrap_top: req=%b addr=%h ret=%0d want 1/1f/31", mem_req_s, mem_addr_s, retired_s);
        end
        cyc = 0;
        while (!(mem_req_s && mem_addr_s != 5'h1F) && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        if ({mem_req_s, mem_addr_s, retired_s} !== {1'b1, 5'h00, 32'd32}) begin
            errors++;
            $display("FAIL wrap_zero: req=%b addr=%h ret=%0d want 1/00/32", mem_req_s, mem_addr_s, retired_s);
        end
        reset_s = 1'b0;
    endtask

    task automatic test_saturate();
        int want;
        sc_rst_n = 1'b0;
        sc_inc = 1'b0;
        tick();
        checks++;
        if (sc_count !== 3'd0) begin
            errors++;
            $display("FAIL sat_reset: got %0d want 0", sc_count);
        end
        sc_rst_n = 1'b1;
        sc_inc = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            want = (k > 7) ? 7 : k;
            checks++;
            if (sc_count !== 3'(want)) begin
                errors++;
                $display("FAIL sat_count[%0d]: got %0d want %0d", k, sc_count, want);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            prog.delete();
            for (int a = 0; a < 64; a++) begin
                case ($urandom_range(0, 9))
                    0:       prog[32'(a)] = 32'hF000_0000;
                    1:       prog[32'(a)] = {4'hE, 28'($urandom_range(0, 63))};
                    default: prog[32'(a)] = {4'($urandom_range(0, 13)), 28'($urandom)};
                endcase
            end
            noise = 1'b1;
            mem_lat = $urandom_range(0, 3);
            exec_lat = $urandom_range(1, 4);
            test_program("rand", 60, 1'b1);
        end
        noise = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_fetch_stall();
        test_jump();
        test_halt();
        test_reset_mid_execute();
        test_wrap();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
